// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
//   Parametrised chain of pipeline registers with per-stage valid bits and a
//   valid/ready handshake on both ends. The ready chain is combinational, so a
//   bubble anywhere in the chain is collapsed in a single cycle. A synchronous
//   flush squashes every stage. The payload is opaque; callers pack their own
//   control and data fields into it.
//
// Parameters
//   WIDTH   payload width in bits (>= 1)
//   STAGES  number of register stages (>= 1, anything less fails elaboration)
//   CNTW    derived occupancy width, $clog2(STAGES+1), not overridable
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous clear of all stages; drops any beat offered
//   in_valid   upstream presents in_data
//   in_ready   chain accepts in_data this cycle (forced low during flush)
//   in_data    upstream payload
//   out_valid  last stage holds a valid payload
//   out_ready  downstream consumes out_data this cycle
//   out_data   last-stage payload, stable while out_valid & ~out_ready
//   occupancy  registered count of stages holding a valid payload
//   stall_cnt  saturating count of edges with out_valid & ~out_ready
//              (only when PIPE_STALL_CNT_EN is defined)
//
// Build option
//   PIPE_STALL_CNT_EN  adds the stall_cnt port and its 16-bit saturating
//                      counter; cleared by reset only, flush leaves it alone.
// -----------------------------------------------------------------------------
module pipe_reg_chain #(
   parameter  int WIDTH  = 32,
   parameter  int STAGES = 2,
   localparam int CNTW   = $clog2(STAGES + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [CNTW-1:0]   occupancy
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   generate
      if (STAGES < 1) begin : g_bad_stages
         $error("pipe_reg_chain: STAGES must be >= 1");
      end
   endgenerate

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] ready;
   logic [STAGES-1:0] down_ready;
   logic [STAGES-1:0] src_valid;
   logic [STAGES-1:0] xfer;
   logic [WIDTH-1:0]  data_q   [STAGES];
   logic [WIDTH-1:0]  src_data [STAGES];
   logic [CNTW-1:0]   occ_d;

   // Ready ripples from the output side back to the input side. down_ready[k]
   // is whatever sits in front of stage k (next stage's ready, or out_ready for
   // the last stage); a stage is ready when it is empty or can pass its beat on.
   always_comb begin
      logic rdy_acc;
      rdy_acc    = out_ready;
      ready      = '0;
      down_ready = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         down_ready[k] = rdy_acc;
         rdy_acc       = ~valid_q[k] | rdy_acc;
         ready[k]      = rdy_acc;
      end
   end

   always_comb begin
      src_valid[0] = in_valid;
      src_data[0]  = in_data;
      for (int k = 1; k < STAGES; k++) begin
         src_valid[k] = valid_q[k-1];
         src_data[k]  = data_q[k-1];
      end
   end

   // A stage that receives a beat becomes valid; a stage whose beat leaves
   // without a replacement empties. Flush outranks both.
   always_comb begin
      occ_d   = '0;
      xfer    = '0;
      valid_d = '0;
      for (int k = 0; k < STAGES; k++) begin
         xfer[k] = ready[k] & src_valid[k];
         if (flush) begin
            valid_d[k] = 1'b0;
         end else begin
            valid_d[k] = xfer[k] | (valid_q[k] & ~down_ready[k]);
         end
         occ_d = occ_d + CNTW'(valid_d[k]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= '0;
         occupancy <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q   <= valid_d;
         occupancy <= occ_d;
         for (int k = 0; k < STAGES; k++) begin
            // Data only moves on a transfer so stalled stages do not toggle.
            if (flush) begin
               data_q[k] <= '0;
            end else if (xfer[k]) begin
               data_q[k] <= src_data[k];
            end
         end
      end
   end

   assign in_ready  = ready[0] & ~flush;
   assign out_valid = valid_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];

`ifdef PIPE_STALL_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;
   localparam int W  = 32;
   localparam int S  = 3;
   localparam int CW = $clog2(S + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [CW-1:0] occupancy;
`ifdef PIPE_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_reg_chain #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an array of slots. Each edge the output slot drains if
   // downstream takes it, then every beat advances one slot if the slot ahead
   // is free, then a new beat enters slot 0 if it is free.
   logic          m_v [S];
   logic [W-1:0]  m_d [S];
   logic          tv  [S];
   logic [W-1:0]  td  [S];

   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < S; i++) c += int'(m_v[i]);
      return c;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset || flush) begin
         for (int i = 0; i < S; i++) begin
            m_v[i] <= 1'b0;
            m_d[i] <= '0;
         end
      end else begin
         tv = m_v;
         td = m_d;
         if (tv[S-1] && out_ready) tv[S-1] = 1'b0;
         for (int i = S - 2; i >= 0; i--) begin
            if (tv[i] && !tv[i+1]) begin
               tv[i+1] = 1'b1;
               td[i+1] = td[i];
               tv[i]   = 1'b0;
            end
         end
         if (in_valid && !tv[0]) begin
            tv[0] = 1'b1;
            td[0] = in_data;
         end
         m_v <= tv;
         m_d <= td;
      end
   end

   bit            run_cmp = 1'b0;
   logic [W-1:0]  rx [$];

   always @(negedge clk) begin
      if (run_cmp && !reset) begin
         check("out_valid", 32'(out_valid), 32'(m_v[S-1]));
         check("out_data", out_data, m_d[S-1]);
         check("in_ready", 32'(in_ready), 32'(!flush && (m_cnt() < S || out_ready)));
         check("occupancy", 32'(occupancy), 32'(m_cnt()));
         if (out_valid && out_ready) rx.push_back(out_data);
      end
   end

   task automatic step(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
   endtask

   int first_out;
   int peak;

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
`ifdef PIPE_STALL_CNT_EN
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      reset   = 1'b0;
      run_cmp = 1'b1;
      step(0, '0, 0, 0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Streaming 1..8 with downstream always ready
      rx.delete();
      first_out = -1;
      peak      = 0;
      for (int i = 0; i < 14; i++) begin
         if (i < 8) step(1, W'(i + 1), 1, 0);
         else       step(0, '0, 1, 0);
         check("t1_in_ready", 32'(in_ready), 32'd1);
         if (out_valid && first_out < 0) first_out = i;
         if (int'(occupancy) > peak) peak = int'(occupancy);
      end
      check("t1_latency", 32'(first_out), 32'd3);
      check("t1_peak_occ", 32'(peak), 32'd3);
      check("t1_rx_count", 32'(rx.size()), 32'd8);
      for (int i = 0; i < rx.size() && i < 8; i++) check("t1_rx_order", rx[i], 32'(i + 1));

      // Fill under backpressure, then release one beat
      rx.delete();
      step(1, 32'hA, 0, 0);
      step(1, 32'hB, 0, 0);
      step(1, 32'hC, 0, 0);
      step(1, 32'hD, 0, 0);
      check("t2_full_in_ready", 32'(in_ready), 32'd0);
      check("t2_full_occ", 32'(occupancy), 32'd3);
      check("t2_full_data", out_data, 32'hA);
      step(1, 32'hD, 0, 0);
      check("t2_stable_data", out_data, 32'hA);
      check("t2_stable_occ", 32'(occupancy), 32'd3);
      step(0, '0, 1, 0);
      check("t2_release_in_ready", 32'(in_ready), 32'd1);
      step(0, '0, 0, 0);
      check("t2_after_data", out_data, 32'hB);
      check("t2_after_occ", 32'(occupancy), 32'd2);
      check("t2_after_in_ready", 32'(in_ready), 32'd1);
      check("t2_rx_first", 32'(rx.size()), 32'd1);
      if (rx.size() > 0) check("t2_rx_a", rx[0], 32'hA);
      repeat (5) step(0, '0, 1, 0);
      check("t2_rx_count", 32'(rx.size()), 32'd3);
      if (rx.size() == 3) begin
         check("t2_rx_b", rx[1], 32'hB);
         check("t2_rx_c", rx[2], 32'hC);
      end

      // Bubble collapse under backpressure
      rx.delete();
      step(1, 32'h5, 0, 0);
      step(0, '0, 0, 0);
      step(1, 32'h6, 0, 0);
      step(0, '0, 0, 0);
      step(0, '0, 0, 0);
      check("t3_occ", 32'(occupancy), 32'd2);
      check("t3_data", out_data, 32'h5);
      step(0, '0, 0, 0);
      check("t3_occ_hold", 32'(occupancy), 32'd2);
      step(0, '0, 1, 0);
      check("t3_out5", out_data, 32'h5);
      step(0, '0, 1, 0);
      check("t3_out6_valid", 32'(out_valid), 32'd1);
      check("t3_out6", out_data, 32'h6);
      step(0, '0, 1, 0);
      step(0, '0, 1, 0);
      check("t3_rx_count", 32'(rx.size()), 32'd2);
      if (rx.size() == 2) begin
         check("t3_rx0", rx[0], 32'h5);
         check("t3_rx1", rx[1], 32'h6);
      end
      check("t3_empty", 32'(occupancy), 32'd0);

      // Flush a full chain while a beat is offered
      rx.delete();
      step(1, 32'h11, 0, 0);
      step(1, 32'h22, 0, 0);
      step(1, 32'h33, 0, 0);
      step(1, 32'hDEAD, 0, 1);
      check("t4_flush_in_ready", 32'(in_ready), 32'd0);
      check("t4_pre_occ", 32'(occupancy), 32'd3);
      step(0, '0, 0, 0);
      check("t4_occ", 32'(occupancy), 32'd0);
      check("t4_out_valid", 32'(out_valid), 32'd0);
      check("t4_out_data", out_data, 32'd0);
      repeat (5) step(0, '0, 1, 0);
      check("t4_no_dead", 32'(rx.size()), 32'd0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(i), 1, 0);
      check("t5_pre_valid", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("t5_async_valid", 32'(out_valid), 32'd0);
      check("t5_async_data", out_data, 32'd0);
      check("t5_async_occ", 32'(occupancy), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rx.delete();
      reset = 1'b0;
      step(0, '0, 1, 0);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      repeat (5) step(0, '0, 1, 0);
      check("t5_no_stale", 32'(rx.size()), 32'd0);
      check("t5_out_valid", 32'(out_valid), 32'd0);

`ifdef PIPE_STALL_CNT_EN
      step(1, 32'h77, 0, 0);
      step(0, '0, 0, 0);
      repeat (65600) @(posedge clk);
      @(negedge clk);
      check("t6_saturate", 32'(stall_cnt), 32'hFFFF);
      step(0, '0, 0, 1);
      step(0, '0, 0, 0);
      check("t6_flush_keep", 32'(stall_cnt), 32'hFFFF);
`endif

      run_cmp = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
